// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding,
// requester index constants and the word-alignment check.
package mem_arb_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SERVE_I = 2'd1;
  localparam logic [1:0] ST_SERVE_D = 2'd2;

  // Requester indices, used for the round-robin "last served" record
  // and as bit positions in the request vector.
  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_DATA  = 1'b1;

  // A word access is aligned when the two byte-offset bits are zero.
  function automatic logic addr_aligned(input logic [1:0] lsb);
    return (lsb == 2'b00);
  endfunction

endpackage : mem_arb_pkg

// File: rtl/rr_arbiter2.sv
// Two-way combinational round-robin pick. Requests whose mask bit is set are
// not eligible. When both are eligible the port that was not served last wins.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic [1:0] i_mask,
  input  logic       i_last,
  output logic       o_valid,
  output logic       o_grant
);

  logic [1:0] w_elig;

  assign w_elig = i_req & ~i_mask;

  // Pick the granted index; on contention alternate away from the last winner.
  always_comb begin
    o_valid = |w_elig;
    o_grant = PORT_FETCH;
    if (w_elig == 2'b11) begin
      o_grant = ~i_last;
    end else if (w_elig[PORT_DATA]) begin
      o_grant = PORT_DATA;
    end
  end

endmodule : rr_arbiter2

// File: rtl/mem_arbiter.sv
// Shares a single-ported byte memory between the instruction-fetch port
// (read-only) and the data load/store port. Each access takes one SERVE cycle
// followed by a one-cycle ack; misaligned words are answered with an error
// and never touch the memory.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int BUSY_TIMEOUT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  // instruction-fetch port
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_err,
  // data load/store port
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  // memory side
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  // There is no timeout logic; the parameter is kept only for interface
  // compatibility and a nonzero value changes nothing.
  if (BUSY_TIMEOUT != 0) begin : g_timeout_unsupported
  end

  logic [1:0]        r_state;
  logic              r_last;
  logic              r_i_ack;
  logic              r_i_err;
  logic [DATA_W-1:0] r_i_rdata;
  logic              r_d_ack;
  logic              r_d_err;
  logic [DATA_W-1:0] r_d_rdata;

  logic [1:0]        w_req;
  logic [1:0]        w_mask;
  logic              w_grant_vld;
  logic              w_grant;
  logic              w_i_aligned;
  logic              w_d_aligned;

  assign w_i_aligned = addr_aligned(i_addr[1:0]);
  assign w_d_aligned = addr_aligned(d_addr[1:0]);

  // A port whose ack is high this cycle is not eligible: its req is still
  // the one just completed.
  assign w_req[PORT_FETCH]  = i_req;
  assign w_req[PORT_DATA]   = d_req;
  assign w_mask[PORT_FETCH] = r_i_ack;
  assign w_mask[PORT_DATA]  = r_d_ack;

  rr_arbiter2 u_rr (
    .i_req   (w_req),
    .i_mask  (w_mask),
    .i_last  (r_last),
    .o_valid (w_grant_vld),
    .o_grant (w_grant)
  );

  // Sequence IDLE -> SERVE_x -> IDLE and remember which port was served last.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_last  <= PORT_FETCH;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_grant_vld) begin
            r_state <= (w_grant == PORT_DATA) ? ST_SERVE_D : ST_SERVE_I;
          end
        end
        ST_SERVE_I: begin
          r_last  <= PORT_FETCH;
          r_state <= ST_IDLE;
        end
        ST_SERVE_D: begin
          r_last  <= PORT_DATA;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Capture the response at the closing edge of SERVE; every response field
  // lasts exactly one cycle and returns to zero otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_i_ack   <= 1'b0;
      r_i_err   <= 1'b0;
      r_i_rdata <= '0;
      r_d_ack   <= 1'b0;
      r_d_err   <= 1'b0;
      r_d_rdata <= '0;
    end else begin
      r_i_ack   <= 1'b0;
      r_i_err   <= 1'b0;
      r_i_rdata <= '0;
      r_d_ack   <= 1'b0;
      r_d_err   <= 1'b0;
      r_d_rdata <= '0;
      if (r_state == ST_SERVE_I) begin
        r_i_ack   <= 1'b1;
        r_i_err   <= ~w_i_aligned;
        r_i_rdata <= w_i_aligned ? mem_rdata : '0;
      end
      if (r_state == ST_SERVE_D) begin
        r_d_ack   <= 1'b1;
        r_d_err   <= ~w_d_aligned;
        // Stores answer with zero data; loads return the pre-write word.
        r_d_rdata <= (w_d_aligned && !d_we) ? mem_rdata : '0;
      end
    end
  end

  // Drive the memory only while serving; the write enable follows the state
  // directly so an asynchronous reset removes it immediately.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_write = 1'b0;
    case (r_state)
      ST_SERVE_I: begin
        mem_addr  = i_addr;
        mem_wdata = d_wdata;
      end
      ST_SERVE_D: begin
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        mem_write = d_we & w_d_aligned;
      end
      default: begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_write = 1'b0;
      end
    endcase
  end

  assign busy    = (r_state == ST_SERVE_I) || (r_state == ST_SERVE_D);
  assign i_ack   = r_i_ack;
  assign i_err   = r_i_err;
  assign i_rdata = r_i_rdata;
  assign d_ack   = r_d_ack;
  assign d_err   = r_d_err;
  assign d_rdata = r_d_rdata;

endmodule : mem_arbiter

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single-ported, little-endian byte memory between two requesters: the instruction-fetch port (read-only) and the data load/store port. It drives the memory's address, write-data and write-enable signals, and receives its combinational read data. Access order is round-robin, so neither port starves. Misaligned word accesses are rejected with an error response and never reach the memory.

Parameters:
ADDR_W, 32, requester and memory address width
DATA_W, 32, word width; fixed at 32 for this design
BUSY_TIMEOUT, 0, reserved; must be 0 (no timeout logic)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
i_req  in  1  fetch request; held until i_ack
i_addr  in  ADDR_W  fetch word address; stable while i_req=1
i_ack  out  1  one-cycle completion pulse for fetch
i_rdata  out  DATA_W  fetched word; valid while i_ack=1
i_err  out  1  misaligned fetch; valid while i_ack=1
d_req  in  1  data request; held until d_ack
d_we  in  1  1 = store, 0 = load; stable while d_req=1
d_addr  in  ADDR_W  data word address
d_wdata  in  DATA_W  store data
d_ack  out  1  one-cycle completion pulse for data
d_rdata  out  DATA_W  load data; valid while d_ack=1
d_err  out  1  misaligned data access; valid while d_ack=1
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_write  out  1  memory write enable, sampled at clk rising edge
mem_rdata  in  DATA_W  combinational memory read data
busy  out  1  1 while in a SERVE state

Behaviour:
- Reset values: state=IDLE, last=FETCH; all acks, errs and rdata regs = 0; mem_write=0.
- Reset is asynchronous. Asserting it mid-SERVE drops the transaction, forces mem_write=0 immediately (no memory write occurs) and issues no ack.
- FSM states: IDLE, SERVE_I, SERVE_D.
- IDLE: the eligible set is the ports with req=1, excluding any port whose ack is high this cycle (its req is ignored during the ack cycle).
  - One port eligible: go to that port's SERVE state.
  - Both eligible: grant the port that is not `last`.
  - None eligible: stay in IDLE.
- SERVE_X (exactly one cycle):
  - mem_addr = X's addr; mem_wdata = d_wdata.
  - mem_write = 1 only in SERVE_D with d_we=1 and d_addr[1:0]=0.
  - At the closing edge: X_rdata <= aligned ? mem_rdata : 0; X_err <= misaligned; X_ack <= 1; last <= X; state <= IDLE.
- Outside SERVE states: mem_addr=0, mem_wdata=0, mem_write=0.
- Latency: request seen in IDLE at cycle N → SERVE at N+1 → ack at N+2. Peak throughput is one access per 2 cycles.
- Loads return the pre-write memory contents. Because state is only IDLE or SERVE, a store and a fetch are never concurrent.
- Store responses: d_rdata=0 and d_err=0, unless the address is misaligned.
- Misaligned access (addr[1:0] != 0): no memory write, rdata=0, err=1, same timing as a normal access.
- Address wrap-around is handled by the memory (low 10 bits used); the arbiter passes the full address unchanged.
- Ack, err and rdata are held for exactly one cycle, then return to 0.
- A requester that raises req in its own ack cycle is considered in the following IDLE cycle.

Decomposition:
- Package mem_arb_pkg:
  - state encoding (IDLE=2'd0, SERVE_I=2'd1, SERVE_D=2'd2)
  - port index constants (PORT_FETCH=1'b0, PORT_DATA=1'b1)
  - alignment-check function
- Sub-module rr_arbiter2: combinational two-way round-robin pick from (req vector, mask, last), returning a valid flag and the granted index. The FSM and datapath muxing stay in mem_arbiter.

Test Plan:
- Reset, then i_req=1, i_addr=0x10, with memory word 0x10 preloaded to 0xDEADBEEF → mem_addr=0x10 in cycle 2, i_ack=1 and i_rdata=0xDEADBEEF in cycle 3, i_err=0.
- d_req=1, d_we=1, d_addr=0x20, d_wdata=0x12345678, then a load of 0x20 → mem_write=1 for exactly one cycle; the load returns 0x12345678 and bytes[0x20]=0x78.
- i_req and d_req both held continuously from reset → grants alternate D, I, D, I (last=FETCH after reset); each ack exactly 2 cycles apart; no port acked twice in a row.
- d_we=1, d_addr=0x22 → d_ack=1 and d_err=1; mem_write stays 0; word at 0x20 unchanged.
- rst_n pulled low in the middle of a SERVE_D store to 0x40 → mem_write drops immediately; no d_ack; memory at 0x40 unchanged; after release, state=IDLE and outputs=0.
- i_req held high through its ack cycle with a new address 0x14 → the second fetch is granted in the next IDLE cycle and acked 2 cycles later with the correct data.
